// File: rtl/spgd_pkg.sv
// Shared defaults and FSM state type for the ADC window controller.
package spgd_pkg;

   localparam int ADC_WIDTH_DEF = 14;
   localparam int ACC_WIDTH_DEF = 32;
   localparam int CNT_WIDTH_DEF = 16;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETTLE,
      ST_ACCUM,
      ST_DONE,
      ST_HOLD
   } state_t;

endpackage

// File: rtl/sat_accumulator.sv
// Saturating signed accumulator with a sticky saturation flag.
// clr has priority over add_en; both act on the rising clock edge.
module sat_accumulator
   import spgd_pkg::*;
#(
   parameter int IN_WIDTH  = ADC_WIDTH_DEF,
   parameter int ACC_WIDTH = ACC_WIDTH_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clr,
   input  logic                 add_en,
   input  logic [IN_WIDTH-1:0]  din,
   output logic [ACC_WIDTH-1:0] acc,
   output logic                 sat
);

   localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
   localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

   logic [ACC_WIDTH-1:0] acc_q, acc_d;
   logic                 sat_q, sat_d;
   logic [ACC_WIDTH:0]   sum;

   always_comb begin
      // one guard bit: overflow shows up as the top two sum bits disagreeing
      sum   = {acc_q[ACC_WIDTH-1], acc_q}
            + {{(ACC_WIDTH+1-IN_WIDTH){din[IN_WIDTH-1]}}, din};
      acc_d = acc_q;
      sat_d = sat_q;
      if (clr) begin
         acc_d = '0;
         sat_d = 1'b0;
      end else if (add_en) begin
         if (sum[ACC_WIDTH] != sum[ACC_WIDTH-1]) begin
            acc_d = sum[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
            sat_d = 1'b1;
         end else begin
            acc_d = sum[ACC_WIDTH-1:0];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_q <= '0;
         sat_q <= 1'b0;
      end else begin
         acc_q <= acc_d;
         sat_q <= sat_d;
      end
   end

   assign acc = acc_q;
   assign sat = sat_q;

endmodule

// File: rtl/adc_window_ctrl.sv
// ADC measurement window: discard SETTLE_CNT samples, sum SAMPLE_CNT samples.
// Define ADC_WINDOW_MINMAX_EN to also report per-window min/max samples.
module adc_window_ctrl
   import spgd_pkg::*;
#(
   parameter int ADC_WIDTH = ADC_WIDTH_DEF,
   parameter int ACC_WIDTH = ACC_WIDTH_DEF,
   parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
   input  logic                 ADC_CLK,
   input  logic                 RST,
   input  logic                 ADC_EN,
   input  logic                 ADC_VALID,
   input  logic [ADC_WIDTH-1:0] ADC_DATA,
   input  logic [CNT_WIDTH-1:0] SETTLE_CNT,
   input  logic [CNT_WIDTH-1:0] SAMPLE_CNT,
   output logic                 ADC_DONE,
   output logic [ACC_WIDTH-1:0] ACC_OUT,
   output logic                 ACC_SAT,
   output logic                 BUSY,
   output logic [ADC_WIDTH-1:0] MIN_OUT,
   output logic [ADC_WIDTH-1:0] MAX_OUT
);

   state_t               state_q, state_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic [CNT_WIDTH-1:0] settle_q, settle_d;
   logic [CNT_WIDTH-1:0] sample_q, sample_d;
   logic                 done_q, done_d;
   logic [ACC_WIDTH-1:0] acc_out_q, acc_out_d;
   logic                 acc_sat_q, acc_sat_d;
   logic                 acc_clr, acc_add;
   logic [ACC_WIDTH-1:0] acc_sum;
   logic                 acc_ovf;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      settle_d  = settle_q;
      sample_d  = sample_q;
      done_d    = 1'b0;
      acc_out_d = acc_out_q;
      acc_sat_d = acc_sat_q;
      acc_clr   = 1'b0;
      acc_add   = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            // a strobe coinciding with window start is deliberately not counted
            if (ADC_EN) begin
               settle_d = SETTLE_CNT;
               sample_d = (SAMPLE_CNT == '0) ? CNT_WIDTH'(1) : SAMPLE_CNT;
               cnt_d    = '0;
               acc_clr  = 1'b1;
               state_d  = (SETTLE_CNT == '0) ? ST_ACCUM : ST_SETTLE;
            end
         end
         ST_SETTLE: begin
            if (!ADC_EN) begin
               state_d = ST_IDLE;
            end else if (ADC_VALID) begin
               if (cnt_q + CNT_WIDTH'(1) == settle_q) begin
                  cnt_d   = '0;
                  state_d = ST_ACCUM;
               end else begin
                  cnt_d = cnt_q + CNT_WIDTH'(1);
               end
            end
         end
         ST_ACCUM: begin
            if (!ADC_EN) begin
               state_d = ST_IDLE;
            end else if (ADC_VALID) begin
               acc_add = 1'b1;
               if (cnt_q + CNT_WIDTH'(1) == sample_q) begin
                  state_d = ST_DONE;
               end else begin
                  cnt_d = cnt_q + CNT_WIDTH'(1);
               end
            end
         end
         ST_DONE: begin
            acc_out_d = acc_sum;
            acc_sat_d = acc_ovf;
            done_d    = 1'b1;
            state_d   = ST_HOLD;
         end
         ST_HOLD: begin
            if (ADC_EN) begin
               done_d = 1'b1;
            end else begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge ADC_CLK or posedge RST) begin
      if (RST) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         settle_q  <= '0;
         sample_q  <= '0;
         done_q    <= 1'b0;
         acc_out_q <= '0;
         acc_sat_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         settle_q  <= settle_d;
         sample_q  <= sample_d;
         done_q    <= done_d;
         acc_out_q <= acc_out_d;
         acc_sat_q <= acc_sat_d;
      end
   end

   sat_accumulator #(
      .IN_WIDTH  (ADC_WIDTH),
      .ACC_WIDTH (ACC_WIDTH)
   ) u_acc (
      .clk    (ADC_CLK),
      .rst    (RST),
      .clr    (acc_clr),
      .add_en (acc_add),
      .din    (ADC_DATA),
      .acc    (acc_sum),
      .sat    (acc_ovf)
   );

   assign ADC_DONE = done_q;
   assign ACC_OUT  = acc_out_q;
   assign ACC_SAT  = acc_sat_q;
   assign BUSY     = (state_q == ST_SETTLE) || (state_q == ST_ACCUM);

`ifdef ADC_WINDOW_MINMAX_EN
   localparam logic [ADC_WIDTH-1:0] ADC_MAX = {1'b0, {(ADC_WIDTH-1){1'b1}}};
   localparam logic [ADC_WIDTH-1:0] ADC_MIN = {1'b1, {(ADC_WIDTH-1){1'b0}}};

   logic [ADC_WIDTH-1:0] min_q, min_d, max_q, max_d;
   logic [ADC_WIDTH-1:0] min_out_q, min_out_d, max_out_q, max_out_d;

   always_comb begin
      min_d     = min_q;
      max_d     = max_q;
      min_out_d = min_out_q;
      max_out_d = max_out_q;
      if (acc_clr) begin
         min_d = ADC_MAX;
         max_d = ADC_MIN;
      end else if (acc_add) begin
         if ($signed(ADC_DATA) < $signed(min_q)) min_d = ADC_DATA;
         if ($signed(ADC_DATA) > $signed(max_q)) max_d = ADC_DATA;
      end
      if (state_q == ST_DONE) begin
         min_out_d = min_q;
         max_out_d = max_q;
      end
   end

   always_ff @(posedge ADC_CLK or posedge RST) begin
      if (RST) begin
         min_q     <= '0;
         max_q     <= '0;
         min_out_q <= '0;
         max_out_q <= '0;
      end else begin
         min_q     <= min_d;
         max_q     <= max_d;
         min_out_q <= min_out_d;
         max_out_q <= max_out_d;
      end
   end

   assign MIN_OUT = min_out_q;
   assign MAX_OUT = max_out_q;
`else
   assign MIN_OUT = '0;
   assign MAX_OUT = '0;
`endif

endmodule
